// File: rtl/spi_xfer_sched_pkg.sv
// spi_xfer_sched shared types: FSM state encoding,
// default word width and error counter width.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/spi_xfer_sched_rr_pick.sv
// rr_pick: combinational round-robin selector.
// req_i/last_grant_i in; one-hot pick_o and its index idx_o out.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW:0]   s;
  logic [IW-1:0] j;
  logic          found;

  // search starts one past the last winner and wraps
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    s      = '0;
    j      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = {1'b0, last_grant_i} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ))
        s = s - (IW+1)'(NUM_REQ);
      j = s[IW-1:0];
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = j;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin scheduler sharing one SPI
// word master among NUM_REQ requesters.
// Ports: clk/rst, req/req_data in; gnt, rsp_valid/rsp_data/
// rsp_err out; mst_start/mst_tx_data to master, mst_done/
// mst_rx_data from master; busy, err_cnt status.
module spi_xfer_sched
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      mst_start,
  output logic [DATA_W-1:0]         mst_tx_data,
  input  logic                      mst_done,
  input  logic [DATA_W-1:0]         mst_rx_data,
  output logic                      busy,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int IW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW =
    (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYC - 1);

  state_e                 state_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [DATA_W-1:0]      rsp_data_q;
  logic                   rsp_err_q;
  logic                   mst_start_q;
  logic [DATA_W-1:0]      tx_q;
  logic [IW-1:0]          last_q;
  logic [TW-1:0]          tmo_q;
  logic [GW-1:0]          gap_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic [NUM_REQ-1:0]     pick;
  logic [IW-1:0]          pick_idx;
  logic [DATA_W-1:0]      sel_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i        (req),
    .last_grant_i (last_q),
    .pick_o       (pick),
    .idx_o        (pick_idx)
  );

  // only the winning slice reaches the mux output
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i])
        sel_data |= req_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mst_start_q <= 1'b0;
      tx_q        <= '0;
      last_q      <= IW'(NUM_REQ - 1);
      tmo_q       <= '0;
      gap_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      mst_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q       <= pick;
            tx_q        <= sel_data;
            last_q      <= pick_idx;
            mst_start_q <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // completion beats expiry on the same cycle
          if (mst_done) begin
            rsp_valid_q <= gnt_q;
            rsp_data_q  <= mst_rx_data;
            state_q     <= ST_RESP;
          end else if (tmo_q == TMO_LAST) begin
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= 1'b1;
            if (err_cnt_q != '1)
              err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            state_q     <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_RESP: begin
          gnt_q   <= '0;
          gap_q   <= '0;
          state_q <= (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST)
            state_q <= ST_IDLE;
          else
            gap_q <= gap_q + GW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mst_start   = mst_start_q;
  assign mst_tx_data = tx_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Randomized self-checking bench for spi_xfer_sched
// against a round-robin / timing reference model.
module tb_spi_xfer_sched;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int TMO = 4096;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  gnt, rsp_valid;
  logic [DW-1:0]  rsp_data, mst_tx_data;
  logic           rsp_err, mst_start, busy;
  logic           mst_done = 1'b0;
  logic [DW-1:0]  mst_rx_data = '0;
  logic [7:0]     err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_last = NR - 1;
  int exp_errs = 0;
  logic [DW-1:0] dw [NR];

  spi_xfer_sched #(
    .NUM_REQ(NR), .DATA_W(DW),
    .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mst_start(mst_start), .mst_tx_data(mst_tx_data),
    .mst_done(mst_done), .mst_rx_data(mst_rx_data),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  // first requester at or after last+1, wrapping
  function automatic int rr_next(
    input logic [NR-1:0] r, input int last);
    logic [NR-1:0] t;
    for (int k = 1; k <= NR; k++) begin
      t = r >> ((last + k) % NR);
      if (t[0]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) begin
      dw[i] = $urandom;
      req_data[i*DW +: DW] = dw[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    mst_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_last = NR - 1;
    exp_errs = 0;
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (gnt == '0 && lat < 60);
    if (gnt == '0) lat = -1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 60) begin
      step();
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_wait: busy=%b want 0", busy);
    end
  endtask

  // done pulse in cycle launch+dly; returns in RESP cycle
  task automatic run_master(input int dly,
                            input logic [DW-1:0] rx);
    repeat (dly) step();
    mst_done = 1'b1;
    mst_rx_data = rx;
    step();
    mst_done = 1'b0;
    mst_rx_data = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({gnt, rsp_valid, rsp_err, mst_start, busy,
         err_cnt, rsp_data, mst_tx_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: gnt=%b rv=%b st=%b busy=%b ec=%0d tx=%h want all 0",
               gnt, rsp_valid, mst_start, busy, err_cnt,
               mst_tx_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    rand_data();
    dw[0] = 32'h3F8A1234;
    req_data[DW-1:0] = dw[0];
    req = 4'b0001;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || mst_start !== 1'b1) begin
      n_bad++;
      $display("FAIL single_gnt: gnt=%b st=%b want 0001/1",
               gnt, mst_start);
    end
    n_cmp++;
    if (mst_tx_data !== 32'h3F8A1234 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_tx: tx=%h busy=%b want 3f8a1234/1",
               mst_tx_data, busy);
    end
    exp_last = 0;
    step();
    n_cmp++;
    if (mst_start !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pulse: st=%b want 0", mst_start);
    end
    run_master(39, 32'h3F8A1235);
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h3F8A1235
        || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_rsp: rv=%b d=%h e=%b want 0001/3f8a1235/0",
               rsp_valid, rsp_data, rsp_err);
    end
    req = '0;
    step();
    n_cmp++;
    if (rsp_valid !== '0 || gnt !== '0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_gap: rv=%b gnt=%b busy=%b want 0/0/1",
               rsp_valid, gnt, busy);
    end
    wait_idle();
  endtask

  // fixed==0 picks a random nonzero pattern per transfer
  task automatic test_rr(input logic [NR-1:0] fixed,
                         input int n);
    int idx, lat;
    logic [NR-1:0] r, eg;
    logic [DW-1:0] rx;
    do_reset();
    r = (fixed != '0) ? fixed :
        NR'($urandom_range(1, (1 << NR) - 1));
    req = r;
    rand_data();
    for (int t = 0; t < n; t++) begin
      wait_gnt(lat);
      idx = rr_next(r, exp_last);
      eg = NR'(1) << idx;
      n_cmp++;
      if (gnt !== eg) begin
        n_bad++;
        $display("FAIL rr_gnt t=%0d: got %b want %b",
                 t, gnt, eg);
      end
      n_cmp++;
      if (lat != ((t == 0) ? 1 : GAP + 2)) begin
        n_bad++;
        $display("FAIL rr_lat t=%0d: got %0d want %0d",
                 t, lat, (t == 0) ? 1 : GAP + 2);
      end
      n_cmp++;
      if (mst_start !== 1'b1 || mst_tx_data !== dw[idx]) begin
        n_bad++;
        $display("FAIL rr_launch t=%0d: st=%b tx=%h want 1/%h",
                 t, mst_start, mst_tx_data, dw[idx]);
      end
      exp_last = idx;
      rx = $urandom;
      run_master($urandom_range(1, 25), rx);
      n_cmp++;
      if (rsp_valid !== eg || rsp_data !== rx
          || rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_rsp t=%0d: rv=%b d=%h e=%b want %b/%h/0",
                 t, rsp_valid, rsp_data, rsp_err, eg, rx);
      end
      if (t == n - 1) r = '0;
      else if (fixed == '0)
        r = NR'($urandom_range(1, (1 << NR) - 1));
      req = r;
      rand_data();
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int lat;
    logic [DW-1:0] rx;
    do_reset();
    rand_data();
    req = 4'b0001;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || mst_start !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_gnt: gnt=%b st=%b want 0001/1",
               gnt, mst_start);
    end
    exp_last = 0;
    repeat (TMO) step();
    n_cmp++;
    if (rsp_valid !== '0) begin
      n_bad++;
      $display("FAIL tmo_early: rv=%b want 0", rsp_valid);
    end
    step();
    exp_errs++;
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1
        || rsp_data !== '0) begin
      n_bad++;
      $display("FAIL tmo_rsp: rv=%b e=%b d=%h want 0001/1/0",
               rsp_valid, rsp_err, rsp_data);
    end
    n_cmp++;
    if (err_cnt !== 8'(exp_errs)) begin
      n_bad++;
      $display("FAIL tmo_cnt: got %0d want %0d",
               err_cnt, exp_errs);
    end
    req = 4'b0010;
    rand_data();
    wait_gnt(lat);
    n_cmp++;
    if (gnt !== 4'b0010 || lat != GAP + 2) begin
      n_bad++;
      $display("FAIL tmo_next_gnt: gnt=%b lat=%0d want 0010/%0d",
               gnt, lat, GAP + 2);
    end
    exp_last = 1;
    rx = $urandom;
    run_master(7, rx);
    n_cmp++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0
        || rsp_data !== rx || err_cnt !== 8'(exp_errs)) begin
      n_bad++;
      $display("FAIL tmo_next_rsp: rv=%b e=%b d=%h ec=%0d want 0010/0/%h/%0d",
               rsp_valid, rsp_err, rsp_data, err_cnt, rx,
               exp_errs);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_tie();
    logic [NR-1:0] eg;
    rand_data();
    req = 4'b0100;
    eg = NR'(1) << rr_next(req, exp_last);
    step();
    n_cmp++;
    if (gnt !== eg) begin
      n_bad++;
      $display("FAIL tie_gnt: got %b want %b", gnt, eg);
    end
    exp_last = 2;
    run_master(TMO, 32'h00000055);
    n_cmp++;
    if (rsp_valid !== eg || rsp_err !== 1'b0
        || rsp_data !== 32'h55) begin
      n_bad++;
      $display("FAIL tie_rsp: rv=%b e=%b d=%h want %b/0/00000055",
               rsp_valid, rsp_err, rsp_data, eg);
    end
    n_cmp++;
    if (err_cnt !== 8'(exp_errs)) begin
      n_bad++;
      $display("FAIL tie_cnt: got %0d want %0d",
               err_cnt, exp_errs);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_withdraw();
    int lat, idx;
    logic [DW-1:0] rx;
    do_reset();
    rand_data();
    req = 4'b1100;
    idx = rr_next(req, exp_last);
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || idx != 2) begin
      n_bad++;
      $display("FAIL wd_gnt: got %b want 0100", gnt);
    end
    exp_last = idx;
    step();
    req = 4'b1000;
    rx = $urandom;
    run_master(9, rx);
    n_cmp++;
    if (rsp_valid !== 4'b0100 || rsp_data !== rx
        || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_rsp: rv=%b d=%h e=%b want 0100/%h/0",
               rsp_valid, rsp_data, rsp_err, rx);
    end
    wait_gnt(lat);
    idx = rr_next(req, exp_last);
    n_cmp++;
    if (gnt !== (NR'(1) << idx) || lat != GAP + 2
        || mst_tx_data !== dw[3]) begin
      n_bad++;
      $display("FAIL wd_next: gnt=%b lat=%0d tx=%h want 1000/%0d/%h",
               gnt, lat, mst_tx_data, GAP + 2, dw[3]);
    end
    exp_last = idx;
    rx = $urandom;
    run_master(3, rx);
    n_cmp++;
    if (rsp_valid !== 4'b1000 || rsp_data !== rx) begin
      n_bad++;
      $display("FAIL wd_next_rsp: rv=%b d=%h want 1000/%h",
               rsp_valid, rsp_data, rx);
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [NR-1:0] eg;
    logic [DW-1:0] rx;
    rand_data();
    req = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL rm_gnt: got %b want 0100", gnt);
    end
    repeat (10) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, rsp_valid, rsp_err, mst_start, busy,
         err_cnt, rsp_data, mst_tx_data} !== '0) begin
      n_bad++;
      $display("FAIL rm_async: gnt=%b busy=%b tx=%h want all 0",
               gnt, busy, mst_tx_data);
    end
    req = '0;
    step();
    step();
    n_cmp++;
    if (rsp_valid !== '0) begin
      n_bad++;
      $display("FAIL rm_norsp: rv=%b want 0", rsp_valid);
    end
    rst = 1'b0;
    exp_last = NR - 1;
    exp_errs = 0;
    rand_data();
    req = 4'b1010;
    eg = NR'(1) << rr_next(req, exp_last);
    wait_gnt(lat);
    n_cmp++;
    if (gnt !== eg || lat != 1 || mst_tx_data !== dw[1]) begin
      n_bad++;
      $display("FAIL rm_ptr: gnt=%b lat=%0d tx=%h want %b/1/%h",
               gnt, lat, mst_tx_data, eg, dw[1]);
    end
    rx = $urandom;
    run_master(5, rx);
    n_cmp++;
    if (rsp_valid !== eg || rsp_data !== rx) begin
      n_bad++;
      $display("FAIL rm_rsp: rv=%b d=%h want %b/%h",
               rsp_valid, rsp_data, eg, rx);
    end
    req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr(4'b1111, 8);
    test_rr('0, 12);
    test_timeout();
    test_tie();
    test_withdraw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
